vector_cache_bank: RTL and testbench



---
 rtl/vector_cache_bank.sv | 117 +++++++++++
 tb/tb_vector_cache_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_cache_bank.sv
// rtl/vector_cache_bank.sv - multi-slot spin/weight vector cache with registered reads and sequenced flush
// Optional feature macro: VECTOR_CACHE_BYPASS_EN (same-cycle write-to-read forwarding).
module vector_cache_bank #(
  parameter int DATAWIDTH = 256,
  parameter int NUM_SLOTS = 4,
  localparam int SLOT_AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 flush_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  input  logic [SLOT_AW-1:0]   waddr_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  input  logic                 rreq_i,
  input  logic [SLOT_AW-1:0]   raddr_i,
  output logic                 rvalid_o,
  output logic                 rhit_o,
  output logic [DATAWIDTH-1:0] rdata_o,
  output logic                 busy_o,
  output logic                 flush_done_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;
  localparam logic [SLOT_AW-1:0] LAST_SLOT = SLOT_AW'(NUM_SLOTS - 1);
  localparam logic [31:0] NUM_SLOTS_U = 32'(NUM_SLOTS);

  logic [0:0]           state;
  logic [SLOT_AW-1:0]   cnt;
  logic [DATAWIDTH-1:0] data [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid;

  logic                 idle;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 w_in_range;
  logic                 r_in_range;
  logic [SLOT_AW-1:0]   w_slot;
  logic [SLOT_AW-1:0]   r_slot;
  logic                 rd_hit;
  logic [DATAWIDTH-1:0] rd_word;

  assign idle     = (state == ST_IDLE);
  assign busy_o   = (state == ST_FLUSH);
  assign wready_o = en_i & idle;
  assign wr_acc   = wvalid_i & wready_o;
  assign rd_acc   = rreq_i & en_i & idle;

  // Out-of-range indices are steered to slot 0 so the array is never addressed past its end;
  // the in-range flags keep such accesses from having any effect.
  assign w_in_range = (32'(waddr_i) < NUM_SLOTS_U);
  assign r_in_range = (32'(raddr_i) < NUM_SLOTS_U);
  assign w_slot     = w_in_range ? waddr_i : '0;
  assign r_slot     = r_in_range ? raddr_i : '0;

  always_comb begin
    rd_hit  = r_in_range & valid[r_slot];
    rd_word = data[r_slot];
`ifdef VECTOR_CACHE_BYPASS_EN
    if (wr_acc && w_in_range && (waddr_i == raddr_i)) begin
      rd_hit  = 1'b1;
      rd_word = wdata_i;
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      valid        <= '0;
      rvalid_o     <= 1'b0;
      rhit_o       <= 1'b0;
      rdata_o      <= '0;
      flush_done_o <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        data[i] <= '0;
      end
    end else if (!en_i) begin
      // Disable drops every valid bit and aborts a flush silently; data words are left in place.
      state        <= ST_IDLE;
      cnt          <= '0;
      valid        <= '0;
      rvalid_o     <= 1'b0;
      rhit_o       <= 1'b0;
      rdata_o      <= '0;
      flush_done_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      rvalid_o     <= rd_acc;
      rhit_o       <= rd_acc & rd_hit;
      rdata_o      <= (rd_acc && rd_hit) ? rd_word : '0;
      if (state == ST_FLUSH) begin
        data[cnt]  <= '0;
        valid[cnt] <= 1'b0;
        if (cnt == LAST_SLOT) begin
          state        <= ST_IDLE;
          flush_done_o <= 1'b1;
        end else begin
          cnt <= cnt + SLOT_AW'(1);
        end
      end else begin
        if (wr_acc && w_in_range) begin
          data[w_slot]  <= wdata_i;
          valid[w_slot] <= 1'b1;
        end
        if (flush_i) begin
          state <= ST_FLUSH;
          cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_cache_bank.sv
// tb/tb_vector_cache_bank.sv - self-checking bench for vector_cache_bank (4-slot and 3-slot instances)
module tb_vector_cache_bank;
  localparam int DW = 256;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          en4 = 1'b0, flush4 = 1'b0, wvalid4 = 1'b0, rreq4 = 1'b0;
  logic [1:0]    waddr4 = '0, raddr4 = '0;
  logic [DW-1:0] wdata4 = '0;
  logic          wready4, rvalid4, rhit4, busy4, done4;
  logic [DW-1:0] rdata4;

  logic          en3 = 1'b0, flush3 = 1'b0, wvalid3 = 1'b0, rreq3 = 1'b0;
  logic [1:0]    waddr3 = '0, raddr3 = '0;
  logic [DW-1:0] wdata3 = '0;
  logic          wready3, rvalid3, rhit3, busy3, done3;
  logic [DW-1:0] rdata3;

  vector_cache_bank #(.DATAWIDTH(DW), .NUM_SLOTS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en4), .flush_i(flush4),
    .wvalid_i(wvalid4), .wready_o(wready4), .waddr_i(waddr4), .wdata_i(wdata4),
    .rreq_i(rreq4), .raddr_i(raddr4), .rvalid_o(rvalid4), .rhit_o(rhit4),
    .rdata_o(rdata4), .busy_o(busy4), .flush_done_o(done4)
  );

  vector_cache_bank #(.DATAWIDTH(DW), .NUM_SLOTS(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .en_i(en3), .flush_i(flush3),
    .wvalid_i(wvalid3), .wready_o(wready3), .waddr_i(waddr3), .wdata_i(wdata3),
    .rreq_i(rreq3), .raddr_i(raddr3), .rvalid_o(rvalid3), .rhit_o(rhit3),
    .rdata_o(rdata3), .busy_o(busy3), .flush_done_o(done3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model of the 4-slot bank: slot contents, valid flags and flush cycles remaining.
  logic [DW-1:0] m_data [NS];
  bit            m_valid [NS];
  int            m_left;
  bit            e_rvalid, e_rhit, e_done;
  logic [DW-1:0] e_rdata;
  bit            m_idle;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) begin
        m_data[i]  = '0;
        m_valid[i] = 1'b0;
      end
      m_left = 0; e_rvalid = 0; e_rhit = 0; e_done = 0; e_rdata = '0;
    end else begin
      m_idle = (m_left == 0);
      e_rvalid = 0; e_rhit = 0; e_done = 0; e_rdata = '0;
      if (!en4) begin
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        m_left = 0;
      end else begin
        if (rreq4 && m_idle) begin
          e_rvalid = 1;
          if (m_valid[raddr4]) begin
            e_rhit  = 1;
            e_rdata = m_data[raddr4];
          end
`ifdef VECTOR_CACHE_BYPASS_EN
          if (wvalid4 && waddr4 == raddr4) begin
            e_rhit  = 1;
            e_rdata = wdata4;
          end
`endif
        end
        if (!m_idle) begin
          m_data[NS - m_left]  = '0;
          m_valid[NS - m_left] = 1'b0;
          m_left--;
          if (m_left == 0) e_done = 1;
        end else begin
          if (wvalid4) begin
            m_data[waddr4]  = wdata4;
            m_valid[waddr4] = 1'b1;
          end
          if (flush4) m_left = NS;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy4, m_left != 0);
      check("flush_done", done4, e_done);
      check("wready", wready4, en4 && (m_left == 0));
      check("rvalid", rvalid4, e_rvalid);
      if (e_rvalid) begin
        check("rhit", rhit4, e_rhit);
        check("rdata", rdata4, e_rdata);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr4(input logic [1:0] a, input logic [DW-1:0] d);
    wvalid4 = 1'b1; waddr4 = a; wdata4 = d;
    cyc();
    wvalid4 = 1'b0;
  endtask

  task automatic rd4(input logic [1:0] a);
    rreq4 = 1'b1; raddr4 = a;
    cyc();
    rreq4 = 1'b0;
  endtask

  logic [DW-1:0] pa5, p11, p22, exp_same, pat;
  logic [3:0]    nib;
  int            nbusy, ndone, nrv;

  initial begin
    pa5 = {32{8'hA5}};
    p11 = {32{8'h11}};
    p22 = {32{8'h22}};
`ifdef VECTOR_CACHE_BYPASS_EN
    exp_same = p22;
`else
    exp_same = p11;
`endif
    en4 = 1'b1;
    en3 = 1'b1;
    #2;
    check("reset rvalid", rvalid4, 0);
    check("reset rhit", rhit4, 0);
    check("reset rdata", rdata4, 0);
    check("reset busy", busy4, 0);
    check("reset done", done4, 0);
    check("reset wready follows en", wready4, 1);
    #10 rst = 1'b0;
    cyc();

    wr4(2'd2, pa5);
    rd4(2'd2);
    check("wr_rd rvalid", rvalid4, 1);
    check("wr_rd rhit", rhit4, 1);
    check("wr_rd rdata", rdata4, pa5);
    rd4(2'd1);
    check("empty slot rvalid", rvalid4, 1);
    check("empty slot rhit", rhit4, 0);
    check("empty slot rdata", rdata4, 0);

    wr4(2'd0, p11);
    wvalid4 = 1'b1; waddr4 = 2'd0; wdata4 = p22;
    rreq4 = 1'b1; raddr4 = 2'd0;
    cyc();
    wvalid4 = 1'b0; rreq4 = 1'b0;
    check("same-cycle rdata", rdata4, exp_same);
    rd4(2'd0);
    check("after same-cycle rdata", rdata4, p22);

    for (int i = 0; i < NS; i++) begin
      nib = 4'(i + 3);
      pat = {64{nib}};
      wr4(2'(i), pat);
    end
    rreq4 = 1'b1;
    for (int i = 0; i < NS; i++) begin
      raddr4 = 2'(i);
      cyc();
      nib = 4'(i + 3);
      pat = {64{nib}};
      check("b2b read rdata", rdata4, pat);
    end
    rreq4 = 1'b0;

    flush4 = 1'b1; wvalid4 = 1'b1; waddr4 = 2'd1; wdata4 = p22;
    cyc();
    flush4 = 1'b0; wvalid4 = 1'b0;
    nbusy = 0; ndone = 0; nrv = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        rreq4 = 1'b1; raddr4 = 2'(i);
        wvalid4 = 1'b1; waddr4 = 2'(i); wdata4 = p11;
      end else begin
        rreq4 = 1'b0; wvalid4 = 1'b0;
      end
      if (i == 1) check("flush wready", wready4, 0);
      if (busy4) nbusy++;
      if (done4) ndone++;
      if (rvalid4) nrv++;
      cyc();
    end
    check("flush busy cycles", nbusy, 4);
    check("flush done pulses", ndone, 1);
    check("flush reads dropped", nrv, 0);
    for (int i = 0; i < NS; i++) begin
      rd4(2'(i));
      check("post-flush rhit", rhit4, 0);
      check("post-flush rdata", rdata4, 0);
    end

    wr4(2'd3, p11);
    flush4 = 1'b1;
    cyc();
    flush4 = 1'b0;
    cyc();
    en4 = 1'b0; rreq4 = 1'b1; raddr4 = 2'd3; wvalid4 = 1'b1; waddr4 = 2'd2; wdata4 = pa5;
    #1 check("en low wready", wready4, 0);
    cyc();
    check("abort busy", busy4, 0);
    check("abort done", done4, 0);
    check("en low rvalid", rvalid4, 0);
    flush4 = 1'b1;
    cyc();
    flush4 = 1'b0;
    check("en low flush ignored", busy4, 0);
    en4 = 1'b1; rreq4 = 1'b0; wvalid4 = 1'b0;
    rd4(2'd3);
    check("abort slot3 rhit", rhit4, 0);
    check("abort slot3 rdata", rdata4, 0);
    rd4(2'd2);
    check("en low write dropped", rhit4, 0);

    wvalid3 = 1'b1; waddr3 = 2'd3; wdata3 = p11;
    #1 check("oor wready", wready3, 1);
    cyc();
    wvalid3 = 1'b0;
    rreq3 = 1'b1; raddr3 = 2'd3;
    cyc();
    rreq3 = 1'b0;
    check("oor rvalid", rvalid3, 1);
    check("oor rhit", rhit3, 0);
    check("oor rdata", rdata3, 0);
    wvalid3 = 1'b1; waddr3 = 2'd2; wdata3 = pa5;
    cyc();
    wvalid3 = 1'b0;
    rreq3 = 1'b1; raddr3 = 2'd2; rreq4 = 1'b1; raddr4 = 2'd0;
    cyc();
    rreq3 = 1'b0; rreq4 = 1'b0;
    check("ns3 slot2 rhit", rhit3, 1);
    check("ns3 slot2 rdata", rdata3, pa5);
    #2 rst = 1'b1;
    #1;
    check("async rst rvalid3", rvalid3, 0);
    check("async rst rhit3", rhit3, 0);
    check("async rst rdata3", rdata3, 0);
    check("async rst rvalid4", rvalid4, 0);
    check("async rst rdata4", rdata4, 0);
    #3 rst = 1'b0;
    cyc();
    check("post-rst rvalid3", rvalid3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
